// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
//   Shared register-file definitions used by decode and the scoreboard:
//   default architectural register address width, the hard-wired zero
//   register index, pending-counter width and the per-counter control bundle.
package reg_scoreboard_pkg;

    // Register file geometry shared with the decode stage.
    localparam int REG_ADDR_WIDTH_DEF = 5;
    localparam int REG_ZERO           = 0;

    // Pending counters hold 0..7, which covers every legal MAX_PEND.
    localparam int PEND_W = 3;

    // Per-register control for one cycle.
    typedef struct packed {
        logic inc;   // accepted issue writes this register
        logic dec;   // writeback retires this register
        logic clr;   // pipeline flush
    } pend_ctl_t;

endpackage

// File: rtl/reg_pend_counter.sv
// reg_pend_counter
//   Outstanding-write counter for one architectural register.
//   Ports:
//     clk, rst      - clock, async active-high reset
//     ctl           - inc / dec / clr requests for this cycle
//     cnt           - registered pending count
//     cnt_nxt       - value cnt takes at the next edge (feeds the total sum)
//     underflow     - retire seen while cnt==0 (sets the sticky error)
//   An untracked register is held at 0 and never reports underflow.
module reg_pend_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int MAX_PEND = 3,
    parameter bit TRACKED  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  pend_ctl_t         ctl,
    output logic [PEND_W-1:0] cnt,
    output logic [PEND_W-1:0] cnt_nxt,
    output logic              underflow
);

    always_comb begin
        cnt_nxt   = cnt;
        underflow = 1'b0;
        if (!TRACKED || ctl.clr) begin
            // flush overrides issue and retire, including underflow detection
            cnt_nxt = '0;
        end else begin
            underflow = ctl.dec && (cnt == '0);
            // inc together with dec cancels out
            if (ctl.inc && !ctl.dec && cnt != PEND_W'(MAX_PEND))
                cnt_nxt = cnt + 1'b1;
            else if (ctl.dec && !ctl.inc && cnt != '0)
                cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Register scoreboard for in-order issue: counts outstanding writes per
//   register and blocks issue on RAW hazards or a full pending counter.
//   Ports:
//     clk, rst                 - clock, async active-high reset
//     issue_valid/issue_ready  - decoded instruction handshake
//     read_en_N/read_addr_N    - source operands
//     write_en/write_addr      - destination
//     retire_valid/addr        - writeback completion
//     flush                    - clears all pending state
//     stall                    - issue_valid && !issue_ready
//     pend_total               - registered sum of all pending counts
//     err                      - sticky retire-underflow flag
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int MAX_PEND       = 3,
    parameter bit ZERO_REG_FIXED = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic                      read_en_1,
    input  logic [REG_ADDR_WIDTH-1:0] read_addr_1,
    input  logic                      read_en_2,
    input  logic [REG_ADDR_WIDTH-1:0] read_addr_2,
    input  logic                      write_en,
    input  logic [REG_ADDR_WIDTH-1:0] write_addr,
    input  logic                      retire_valid,
    input  logic [REG_ADDR_WIDTH-1:0] retire_addr,
    input  logic                      flush,
    output logic                      stall,
    output logic [REG_ADDR_WIDTH+2:0] pend_total,
    output logic                      err
);

    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
    localparam int TOT_W    = REG_ADDR_WIDTH + 3;

    logic [NUM_REGS-1:0][PEND_W-1:0] pend;
    logic [NUM_REGS-1:0][PEND_W-1:0] pend_nxt;
    logic [NUM_REGS-1:0]             underflow;
    logic                            issue_acc;

    function automatic logic tracked(input logic [REG_ADDR_WIDTH-1:0] a);
        return !ZERO_REG_FIXED || (int'(a) != REG_ZERO);
    endfunction

    // Hazard and full checks look only at registered counts, so a retire
    // this cycle unblocks issue one cycle later.
    logic raw_1, raw_2, full;
    assign raw_1 = read_en_1 && tracked(read_addr_1) && (pend[read_addr_1] != '0);
    assign raw_2 = read_en_2 && tracked(read_addr_2) && (pend[read_addr_2] != '0);
    assign full  = write_en  && tracked(write_addr)  && (pend[write_addr] == PEND_W'(MAX_PEND));

    assign issue_ready = !rst && !flush && !raw_1 && !raw_2 && !full;
    assign stall       = issue_valid && !issue_ready;
    assign issue_acc   = issue_valid && issue_ready;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_pend
        pend_ctl_t ctl;
        assign ctl.inc = issue_acc && write_en && (write_addr == REG_ADDR_WIDTH'(i));
        assign ctl.dec = retire_valid && (retire_addr == REG_ADDR_WIDTH'(i));
        assign ctl.clr = flush;

        reg_pend_counter #(
            .MAX_PEND (MAX_PEND),
            .TRACKED  (!(ZERO_REG_FIXED && i == REG_ZERO))
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .ctl       (ctl),
            .cnt       (pend[i]),
            .cnt_nxt   (pend_nxt[i]),
            .underflow (underflow[i])
        );
    end

    // Summing next-state values keeps pend_total aligned with the counters.
    logic [TOT_W-1:0] total_nxt;
    always_comb begin
        total_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            total_nxt = total_nxt + TOT_W'(pend_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_total <= '0;
            err        <= 1'b0;
        end else begin
            pend_total <= total_nxt;
            if (|underflow) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    localparam int AW = 5;
    localparam int MP = 3;
    localparam int NR = 2**AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, issue_ready;
    logic          read_en_1, read_en_2, write_en, retire_valid, flush;
    logic [AW-1:0] read_addr_1, read_addr_2, write_addr, retire_addr;
    logic          stall, err;
    logic [AW+2:0] pend_total;

    reg_scoreboard #(.REG_ADDR_WIDTH(AW), .MAX_PEND(MP), .ZERO_REG_FIXED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .read_en_1(read_en_1), .read_addr_1(read_addr_1),
        .read_en_2(read_en_2), .read_addr_2(read_addr_2),
        .write_en(write_en), .write_addr(write_addr),
        .retire_valid(retire_valid), .retire_addr(retire_addr),
        .flush(flush), .stall(stall), .pend_total(pend_total), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding writes per register plus sticky error.
    int pend_m[NR];
    bit err_m;
    int errors = 0;
    int checks = 0;

    function automatic bit trk(input int a);
        return a != 0;
    endfunction

    function automatic bit exp_ready();
        if (rst || flush) return 1'b0;
        if (read_en_1 && trk(read_addr_1) && pend_m[read_addr_1] != 0) return 1'b0;
        if (read_en_2 && trk(read_addr_2) && pend_m[read_addr_2] != 0) return 1'b0;
        if (write_en && trk(write_addr) && pend_m[write_addr] == MP) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int exp_total();
        int s = 0;
        for (int i = 0; i < NR; i++) s += pend_m[i];
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) pend_m[i] = 0;
        err_m = 1'b0;
    endtask

    task automatic set_in(input bit iv, input bit r1e, input int r1a, input bit r2e, input int r2a,
                          input bit we, input int wa, input bit rv, input int ra, input bit fl);
        issue_valid  = iv;
        read_en_1    = r1e; read_addr_1 = AW'(r1a);
        read_en_2    = r2e; read_addr_2 = AW'(r2a);
        write_en     = we;  write_addr  = AW'(wa);
        retire_valid = rv;  retire_addr = AW'(ra);
        flush        = fl;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock, updating the model from the rules for that edge.
    task automatic tick();
        bit acc, inc, dec;
        int wa, ra;
        acc = issue_valid && exp_ready();
        wa  = int'(write_addr);
        ra  = int'(retire_addr);
        inc = acc && write_en && trk(wa);
        dec = retire_valid && trk(ra);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (flush) begin
            for (int i = 0; i < NR; i++) pend_m[i] = 0;
        end else begin
            if (dec && pend_m[ra] == 0) err_m = 1'b1;
            if (!(inc && dec && wa == ra)) begin
                if (inc) pend_m[wa]++;
                if (dec && pend_m[ra] > 0) pend_m[ra]--;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", issue_ready); end
        checks++; if (pend_total !== '0) begin errors++; $display("FAIL reset_total: got %0d expected 0", pend_total); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
        tick(); tick();
        rst = 1'b0;
        tick();
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0b expected 1", issue_ready); end
    endtask

    task automatic test_raw();
        set_in(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_write_ready: got %0b expected 1", issue_ready); end
        tick();
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %0b expected 1", stall); end
        // retire arrives while the read waits; still blocked this cycle
        set_in(1, 1, 5, 0, 0, 0, 0, 1, 5, 0); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass: got %0b expected 1", stall); end
        tick();
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got %0b expected 1", issue_ready); end
        tick();
        idle();
    endtask

    task automatic test_full();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
            tick();
        end
        checks++; if (pend_total !== 8'd3) begin errors++; $display("FAIL full_total: got %0d expected 3", pend_total); end
        set_in(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %0b expected 1", stall); end
        tick();
        checks++; if (pend_total !== 8'd3) begin errors++; $display("FAIL full_hold: got %0d expected 3", pend_total); end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick(); idle();
    endtask

    task automatic test_same_cycle();
        set_in(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 1, 7, 1, 7, 0); tick();
        checks++; if (pend_total !== 8'd1) begin errors++; $display("FAIL same_total: got %0d expected 1", pend_total); end
        set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL same_still_pending: got %0b expected 1", stall); end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); tick();
        checks++; if (pend_total !== 8'd0) begin errors++; $display("FAIL same_drain: got %0d expected 0", pend_total); end
        idle();
    endtask

    task automatic test_underflow();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL uflow_err: got %0b expected 1", err); end
        checks++; if (pend_total !== 8'd0) begin errors++; $display("FAIL uflow_total: got %0d expected 0", pend_total); end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL uflow_flush_keep: got %0b expected 1", err); end
        // mid-cycle async reset clears everything at once
        idle();
        set_in(1, 0, 0, 0, 0, 1, 12, 0, 0, 0); tick(); idle();
        #2 rst = 1'b1; model_clear(); #1;
        checks++; if (err !== 1'b0 || pend_total !== '0) begin errors++; $display("FAIL async_reset: got err=%0b total=%0d expected 0/0", err, pend_total); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_reg();
        for (int k = 0; k < 5; k++) begin
            set_in(1, 1, 0, 1, 0, 1, 0, (k == 4), 0, 0); #1;
            checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %0b expected 1", issue_ready); end
            tick();
        end
        checks++; if (pend_total !== 8'd0 || err !== 1'b0) begin errors++; $display("FAIL zero_state: got total=%0d err=%0b expected 0/0", pend_total, err); end
        idle();
    endtask

    task automatic test_flush();
        set_in(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); tick(); tick();
        set_in(1, 0, 0, 0, 0, 1, 6, 0, 0, 0); tick();
        checks++; if (pend_total !== 8'd4) begin errors++; $display("FAIL flush_pre_total: got %0d expected 4", pend_total); end
        set_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_raw_r2: got %0b expected 1", stall); end
        set_in(1, 0, 0, 0, 0, 1, 8, 1, 4, 1); #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b expected 0", issue_ready); end
        tick();
        checks++; if (pend_total !== 8'd0) begin errors++; $display("FAIL flush_total: got %0d expected 0", pend_total); end
        set_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_raw_clear: got %0b expected 1", issue_ready); end
        tick(); idle();
    endtask

    task automatic test_random();
        bit er;
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 9) < 7,
                   $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 24) == 0);
            #1;
            er = exp_ready();
            checks++; if (issue_ready !== er) begin errors++; $display("FAIL rnd_ready c=%0d: got %0b expected %0b", c, issue_ready, er); end
            checks++; if (stall !== (issue_valid && !er)) begin errors++; $display("FAIL rnd_stall c=%0d: got %0b expected %0b", c, stall, issue_valid && !er); end
            tick();
            checks++; if (pend_total !== 8'(exp_total())) begin errors++; $display("FAIL rnd_total c=%0d: got %0d expected %0d", c, pend_total, exp_total()); end
            checks++; if (err !== err_m) begin errors++; $display("FAIL rnd_err c=%0d: got %0b expected %0b", c, err, err_m); end
        end
        idle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_raw();
        test_full();
        test_same_cycle();
        test_underflow();
        test_zero_reg();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
- REG_ADDR_WIDTH, 5, register address width; register count = 2**REG_ADDR_WIDTH.
- MAX_PEND, 3, maximum outstanding writes per register (1..7).
- ZERO_REG_FIXED, 1, when 1, register 0 is never tracked.

REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- issue_valid, in, 1, decoded instruction present.
- issue_ready, out, 1, instruction accepted this cycle.
- read_en_1, in, 1, source 1 used.
- read_addr_1, in, REG_ADDR_WIDTH, source 1 register.
- read_en_2, in, 1, source 2 used.
- read_addr_2, in, REG_ADDR_WIDTH, source 2 register.
- write_en, in, 1, destination used.
- write_addr, in, REG_ADDR_WIDTH, destination register.
- retire_valid, in, 1, writeback completed.
- retire_addr, in, REG_ADDR_WIDTH, register written back.
- flush, in, 1, pipeline flush.
- stall, out, 1, issue_valid and not issue_ready.
- pend_total, out, REG_ADDR_WIDTH+3, sum of all pending counts.
- err, out, 1, sticky retire-underflow flag.

Function
REQ-003 The block SHALL hold one counter pend[r] per register, range 0..MAX_PEND.
REQ-004 A register r SHALL be "tracked" unless ZERO_REG_FIXED=1 and r=0.
REQ-005 A RAW hazard SHALL exist when a source is enabled, its register is tracked, and its pend is not 0.
REQ-006 A full condition SHALL exist when write_en=1, write_addr is tracked, and pend[write_addr]=MAX_PEND.
REQ-007 issue_ready SHALL equal not flush AND no RAW hazard AND no full condition; it is combinational from current counters and inputs, independent of issue_valid.
REQ-008 Hazard and full checks SHALL use registered counter values only; a retire in cycle N unblocks issue in cycle N+1 at the earliest (no same-cycle bypass).
REQ-009 On issue_valid and issue_ready with write_en=1 to a tracked register, pend[write_addr] SHALL increment at the next edge.
REQ-010 On retire_valid=1 to a tracked register with pend>0, pend[retire_addr] SHALL decrement at the next edge.
REQ-011 An accepted issue and a retire to the same register in the same cycle SHALL leave its pend unchanged.
REQ-012 A retire to a register with pend=0 SHALL leave pend at 0 and set err=1 at the next edge; err stays 1 until rst.
REQ-013 A retire or issue to an untracked register SHALL have no effect and SHALL NOT set err.
REQ-014 flush=1 SHALL clear every pend to 0 at the next edge, overriding same-cycle issue and retire; err is unaffected by flush.
REQ-015 pend_total SHALL be registered and equal the sum of all pend values after each edge.
REQ-016 stall SHALL equal issue_valid AND NOT issue_ready, combinationally.

Reset
REQ-017 rst=1 SHALL asynchronously set all pend to 0, pend_total to 0, and err to 0.
REQ-018 While rst=1, issue_ready SHALL be 0; rst asserted mid-operation SHALL discard all outstanding state.

Structure
REQ-019 REG_ADDR_WIDTH's default and the register-0 index SHALL come from the shared bus definitions header used by the decode stage.
REQ-020 The per-register counter, with inc/dec/clear/underflow logic, SHALL be a sub-module reg_pend_counter instantiated 2**REG_ADDR_WIDTH times by a generate loop.

Verification
REQ-021 The testbench SHALL cover at least the following directed scenarios:
- Issue write to r5, then issue read of r5 the next cycle -> stall=1; retire r5 -> issue_ready=1 one cycle later.
- Three accepted issues writing r3 with MAX_PEND=3, then a fourth -> stall=1; pend_total=3.
- Same-cycle accepted issue writing r7 and retire r7 with pend[r7]=1 -> pend[r7] stays 1.
- Retire r9 with pend=0 -> err=1 and stays 1 through a flush; cleared only by rst.
- Write/read of r0 with ZERO_REG_FIXED=1 -> never stalls, pend_total=0.
- Flush with pend_total=4 -> pend_total=0 next cycle; a pending RAW on r2 clears.
